// File: rtl/mul_issue_stage.sv
// mul_issue_stage: control stage in front of a sequential shift-and-add
// multiplier. It takes one operand pair, holds it steady while the
// multiplier works, and passes the product downstream. A zero operand can
// skip the multiplier, and a watchdog stops a lost finished pulse from
// stalling the pipe.
module mul_issue_stage #(
  parameter int BITS        = 8,
  parameter int TIMEOUT     = 2*BITS+4,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [BITS-1:0]   i_a,
  input  logic [BITS-1:0]   i_b,
  output logic              o_start,
  output logic [BITS-1:0]   o_multiplicand,
  output logic [BITS-1:0]   o_multiplier,
  input  logic              i_finished,
  input  logic [2*BITS-1:0] i_product,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2*BITS-1:0] o_product,
  output logic              o_error,
  output logic              o_busy
);

  // The watchdog must outlast a nominal multiply of BITS cycles.
  if (TIMEOUT <= BITS) begin : g_bad_timeout
    $error("mul_issue_stage: TIMEOUT must be greater than BITS");
  end

  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [BITS-1:0]     a_q, b_q;
  logic [2*BITS-1:0]   prod_q;
  logic                err_q;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic                zero_op;
  logic                timeout_hit;

  assign accept      = (state == IDLE) && i_valid;
  assign zero_op     = ZERO_BYPASS && ((i_a == '0) || (i_b == '0));
  assign timeout_hit = (cnt == CW'(TIMEOUT-1));

  // Next-state logic. In BUSY a finished pulse takes priority over the
  // watchdog, so a result that arrives on the last allowed cycle is kept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = zero_op ? DONE : START;
      START: state_nxt = BUSY;
      BUSY:  if (i_finished || timeout_hit) state_nxt = DONE;
      DONE:  if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any in-flight op without producing a result.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Operand registers: loaded only on accept, so the multiplier sees stable
  // inputs from START through the end of BUSY.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= i_a;
      b_q <= i_b;
    end
  end

  // Watchdog counter: cleared in START and advanced in BUSY. It stops at
  // TIMEOUT-1 because the state leaves BUSY on that cycle, so it never wraps.
  always_ff @(posedge i_clock) begin
    if (i_reset)                            cnt <= '0;
    else if (state == START)                cnt <= '0;
    else if (state == BUSY && !timeout_hit) cnt <= cnt + 1'b1;
  end

  // Result capture: bypass zero, real product, or abort. All three are held
  // through DONE until the downstream handshake completes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prod_q <= '0;
      err_q  <= 1'b0;
    end else if (accept && zero_op) begin
      prod_q <= '0;
      err_q  <= 1'b0;
    end else if (state == BUSY && i_finished) begin
      prod_q <= i_product;
      err_q  <= 1'b0;
    end else if (state == BUSY && timeout_hit) begin
      prod_q <= '0;
      err_q  <= 1'b1;
    end
  end

  assign o_ready        = (state == IDLE);
  assign o_start        = (state == START);
  assign o_valid        = (state == DONE);
  assign o_busy         = (state != IDLE);
  assign o_multiplicand = a_q;
  assign o_multiplier   = b_q;
  assign o_product      = prod_q;
  assign o_error        = err_q;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Bench for mul_issue_stage. A behavioural multiplier answers o_start after a
// programmable delay, and a scoreboard checks every result that leaves the
// stage. A second instance is built with the zero bypass turned off.
module tb_mul_issue_stage;
  localparam int BITS = 8;
  localparam int TO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT, bypass enabled
  logic        vld = 1'b0, rdy_dn = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic        ready, start, valid, error, busy, fin;
  logic [7:0]  mcand, mplier;
  logic [15:0] prod_in, product;

  mul_issue_stage #(.BITS(BITS), .TIMEOUT(TO), .ZERO_BYPASS(1'b1)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_valid(vld), .o_ready(ready),
    .i_a(a), .i_b(b), .o_start(start), .o_multiplicand(mcand),
    .o_multiplier(mplier), .i_finished(fin), .i_product(prod_in),
    .o_valid(valid), .i_ready(rdy_dn), .o_product(product),
    .o_error(error), .o_busy(busy));

  // second DUT, bypass disabled
  logic        vld1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        ready1, start1, valid1, error1, busy1, fin1;
  logic [7:0]  mcand1, mplier1;
  logic [15:0] prod_in1, product1;

  mul_issue_stage #(.BITS(BITS), .TIMEOUT(TO), .ZERO_BYPASS(1'b0)) u_dut_nb (
    .i_clock(clk), .i_reset(rst), .i_valid(vld1), .o_ready(ready1),
    .i_a(a1), .i_b(b1), .o_start(start1), .o_multiplicand(mcand1),
    .o_multiplier(mplier1), .i_finished(fin1), .i_product(prod_in1),
    .o_valid(valid1), .i_ready(1'b1), .o_product(product1),
    .o_error(error1), .o_busy(busy1));

  // multiplier models: finished arrives m_delay cycles after the start cycle
  // (0 = never). fin_force injects stray pulses; ovr replaces the product.
  int          m_delay = 8;
  int          m_cnt, m_cnt1;
  logic        fin_force = 1'b0, ovr_en = 1'b0;
  logic [15:0] ovr = '0;

  always @(posedge clk) begin
    if (rst)             m_cnt <= 0;
    else if (start)      m_cnt <= m_delay;
    else if (m_cnt > 0)  m_cnt <= m_cnt - 1;
  end
  assign fin     = (m_cnt == 1) || fin_force;
  assign prod_in = ovr_en ? ovr : ({8'h00, mcand} * {8'h00, mplier});

  always @(posedge clk) begin
    if (rst)             m_cnt1 <= 0;
    else if (start1)     m_cnt1 <= 8;
    else if (m_cnt1 > 0) m_cnt1 <= m_cnt1 - 1;
  end
  assign fin1     = (m_cnt1 == 1);
  assign prod_in1 = {8'h00, mcand1} * {8'h00, mplier1};

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard entries are {error, product}
  logic [16:0] sb[$];
  int   start_cnt = 0, start_cyc = 0, vrise_cyc = 0, start1_cnt = 0;
  logic valid_d = 1'b0;

  // Output monitor: tracks start pulses and valid edges, retires results.
  always @(negedge clk) begin
    if (rst) begin
      valid_d = 1'b0;
    end else begin
      if (start)  begin start_cnt++; start_cyc = cyc; end
      if (start1) start1_cnt++;
      if (valid && !valid_d) vrise_cyc = cyc;
      valid_d = valid;
      if (valid && rdy_dn) begin
        if (sb.size() == 0) chk("sb_unexpected_result", sb.size(), 1);
        else begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("sb_product", product, e[15:0]);
          chk("sb_error", error, e[16]);
        end
      end
    end
  end

  int acc_cyc = 0;

  task automatic send(input logic [7:0] xa, input logic [7:0] xb,
                      input logic push, input logic [15:0] ep, input logic ee);
    int n = 0;
    @(posedge clk); #1;
    vld = 1'b1; a = xa; b = xb;
    while (!ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("accept_timeout", n, 0);
    if (push) sb.push_back({ee, ep});
    @(posedge clk); #1;
    acc_cyc = cyc;
    vld = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 300) begin @(negedge clk); #1; n++; end
    if (n >= 300) chk("drain_timeout", n, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 300) begin @(negedge clk); #1; n++; end
    if (n >= 300) chk("valid_timeout", n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int s0, n;
    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_start", start, 0);
    chk("rst_valid", valid, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    chk("rst_operands", {mcand, mplier}, 0);
    rst = 1'b0;

    // nominal op
    m_delay = 8; s0 = start_cnt;
    send(8'd13, 8'd11, 1'b1, 16'd143, 1'b0);
    wait_done();
    chk("t1_start_count", start_cnt - s0, 1);
    chk("t1_start_lat", start_cyc - acc_cyc, 0);
    chk("t1_valid_lat", vrise_cyc - acc_cyc, BITS+1);

    // zero bypass, both operand positions
    s0 = start_cnt;
    send(8'd0, 8'd200, 1'b1, 16'd0, 1'b0);
    wait_done();
    chk("byp_no_start", start_cnt - s0, 0);
    chk("byp_valid_lat", vrise_cyc - acc_cyc, 0);
    send(8'd77, 8'd0, 1'b1, 16'd0, 1'b0);
    wait_done();
    chk("byp_b_no_start", start_cnt - s0, 0);

    // bypass disabled: zero operand goes through the multiplier
    @(posedge clk); #1;
    vld1 = 1'b1; a1 = 8'd0; b1 = 8'd200;
    @(posedge clk); #1;
    vld1 = 1'b0;
    s0 = cyc; n = 0;
    while (!valid1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("nb_valid_lat", cyc - s0, BITS+1);
    chk("nb_product", product1, 0);
    chk("nb_error", error1, 0);
    chk("nb_start_count", start1_cnt, 1);

    // backpressure: result held while downstream stalls
    rdy_dn = 1'b0;
    send(8'd255, 8'd255, 1'b1, 16'hFE01, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_valid", valid, 1);
      chk("bp_ready", ready, 0);
      chk("bp_product", product, 16'hFE01);
    end
    @(posedge clk); #1;
    rdy_dn = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", ready, 1);
    chk("bp_valid_drop", valid, 0);

    // watchdog abort, then a normal op
    m_delay = 0;
    send(8'd9, 8'd9, 1'b1, 16'd0, 1'b1);
    wait_done();
    chk("to_lat", vrise_cyc - start_cyc, TO+1);
    m_delay = 8;
    send(8'd3, 8'd5, 1'b1, 16'd15, 1'b0);
    wait_done();
    chk("to_recover_lat", vrise_cyc - acc_cyc, BITS+1);

    // reset in BUSY, late finished ignored
    m_delay = 0;
    send(8'd7, 8'd9, 1'b0, 16'd0, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("mr_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_ready", ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_valid", valid, 0);
    chk("mr_product", product, 0);
    chk("mr_operand", mcand, 0);
    ovr_en = 1'b1; ovr = 16'hBEEF; fin_force = 1'b1;
    @(posedge clk); #1;
    fin_force = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("mr_late_fin", {valid, busy, ready}, 3'b001);
    end
    chk("idle_fin_product", product, 0);

    // stray finished while DONE is held
    ovr_en = 1'b0; m_delay = 8; rdy_dn = 1'b0;
    send(8'd6, 8'd7, 1'b1, 16'd42, 1'b0);
    wait_valid();
    ovr_en = 1'b1; fin_force = 1'b1;
    @(posedge clk); #1;
    fin_force = 1'b0;
    chk("done_fin_valid", valid, 1);
    chk("done_fin_product", product, 16'd42);
    chk("done_fin_error", error, 0);
    ovr_en = 1'b0; rdy_dn = 1'b1;
    wait_done();

    // finished on the last watchdog cycle wins
    m_delay = TO;
    send(8'd12, 8'd10, 1'b1, 16'd120, 1'b0);
    wait_done();
    chk("tie_valid_lat", vrise_cyc - acc_cyc, TO+1);

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_issue_stage.md
Name: mul_issue_stage

Overview:
- Upstream control stage for the sequential shift-and-add multiplier.
- Accepts operand pairs on a valid/ready handshake and holds them stable for the multiplier's full operation.
- Issues a single-cycle start pulse, waits for the multiplier's finished pulse, then captures the 2*BITS product and presents it downstream on a valid/ready handshake.
- Adds a zero-operand bypass and a watchdog timeout so a lost finished pulse cannot hang the pipeline.

Parameters:
- BITS, 8, operand width; the product is 2*BITS wide.
- TIMEOUT, 2*BITS+4, cycles spent in BUSY without i_finished before the op is aborted; must be greater than BITS.
- ZERO_BYPASS, 1, when 1 a zero operand skips the multiplier and returns product 0.

Ports:
- i_clock  input  1  rising-edge clock, the only clock.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  stage can accept an operand pair.
- i_a  input  BITS  multiplicand from upstream.
- i_b  input  BITS  multiplier from upstream.
- o_start  output  1  one-cycle start pulse to the multiplier.
- o_multiplicand  output  BITS  latched multiplicand to the multiplier.
- o_multiplier  output  BITS  latched multiplier to the multiplier.
- i_finished  input  1  multiplier completion pulse.
- i_product  input  2*BITS  multiplier result; valid in the i_finished cycle.
- o_valid  output  1  result valid downstream.
- i_ready  input  1  downstream accepts the result.
- o_product  output  2*BITS  captured result.
- o_error  output  1  result is a timeout abort; qualified by o_valid.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State becomes IDLE; all registers clear.
  - o_ready=1, all other outputs 0 (o_start, o_valid, o_error, o_busy, o_product, o_multiplicand, o_multiplier).
  - Reset asserted mid-operation aborts the op immediately, with no output and no error. The multiplier is reset by the same i_reset.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - o_ready=1.
  - Accept when i_valid & o_ready at a rising edge: latch i_a and i_b into the operand registers.
  - If ZERO_BYPASS=1 and (i_a==0 or i_b==0): o_product<=0, o_error<=0, go to DONE. The multiplier is never started.
  - Otherwise go to START.
  - o_ready is 0 in every other state. There is no accept while an op is in flight.
- START:
  - o_start=1 for exactly this one cycle.
  - Watchdog counter cleared; go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - On i_finished=1: o_product<=i_product, o_error<=0, go to DONE.
  - Else if counter==TIMEOUT-1: o_product<=0, o_error<=1, go to DONE.
  - If i_finished and the timeout coincide, i_finished wins.
- DONE:
  - o_valid=1; o_product and o_error are held stable until the handshake.
  - On i_ready=1: o_valid drops next cycle, go to IDLE.
- Operand outputs:
  - o_multiplicand and o_multiplier reflect the latched registers.
  - Constant from the accept edge until the next accept, so they are stable through START and BUSY.
- Ignored inputs:
  - i_finished is ignored in IDLE, START and DONE; no state change and no error.
  - i_product is only sampled in BUSY with i_finished.
- Latency, with accept at edge T:
  - o_start is high in cycle T+1.
  - o_valid rises the cycle after i_finished is sampled.
  - With the nominal multiplier, finished arrives BITS cycles after the start cycle, so o_valid rises at T+BITS+2.
  - Bypass: o_valid rises at T+1.
- Throughput: at most one op per BITS+3 cycles with i_ready held high.
- Width: the watchdog counter is $clog2(TIMEOUT+1) bits wide and never wraps; it is cleared in START.

Test Plan:
- BITS=8, accept a=13, b=11; model raises i_finished 8 cycles after o_start with product 143 -> exactly one o_start pulse, o_valid one cycle after finished, o_product=16'd143, o_error=0.
- a=0, b=200, ZERO_BYPASS=1 -> o_start never asserts, o_valid at T+1, o_product=0; repeat with ZERO_BYPASS=0 -> normal start/finished path.
- a=255, b=255, i_ready held low 5 cycles after o_valid -> o_product=16'hFE01 held with o_valid=1 and o_ready=0 throughout; o_ready returns 1 the cycle after i_ready.
- TIMEOUT=20, model never raises i_finished -> o_valid with o_error=1 and o_product=0 exactly 20 cycles after entering BUSY; next op then completes normally.
- Assert i_reset for 1 cycle mid-BUSY -> next cycle IDLE, o_ready=1, o_busy=0, no o_valid; a late i_finished pulse is ignored.
- Pulse i_finished in IDLE and in DONE -> no state or output change; i_finished on the same cycle the counter reaches TIMEOUT-1 -> o_error=0 and the real product is captured.
